// File: rtl/dot_pkg.sv
// dot_pkg: shared types and default timing for the dot-matrix button front end
// and scroller.
//   state_e : stepper FSM states
//   dir_e   : step direction (DIR_LEFT=0, DIR_RIGHT=1)
//   DEF_*   : default timing constants (cycles of the system clock)
package dot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_HELD,
    ST_LOCK
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int unsigned DEF_DEBOUNCE_CYC  = 250000;
  localparam int unsigned DEF_REPEAT_DELAY  = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 6250000;
  localparam int unsigned DEF_CNT_W         = 32;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus debounce counter for one raw
// active-low push button.
//   clk     in  system clock
//   rst     in  synchronous active-high reset (level returns to released)
//   btn_n   in  raw button, active-low, asynchronous
//   pressed out debounced level, 1 = pressed
// The debounced level flips only after the synced input has disagreed with it
// for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce
  import dot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser stores the pressed polarity, so reset value 0 = released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = level_q;

endmodule

// File: rtl/dot_btn_stepper.sv
// dot_btn_stepper: turns two raw active-low buttons into step requests held in
// a req/ack handshake for a consumer on a slow clock.
//   clk, rst          system clock, synchronous active-high reset
//   btn_left/right    raw buttons, active-low, asynchronous
//   req_left/right    pending step (at most one high), held until step_ack
//   step_ack          consumer has taken the pending step
//   pressed[1:0]      debounced levels {right,left}, 1 = pressed
//   drop_cnt[7:0]     saturating count of events lost while a step was pending
// Build option AUTO_REPEAT_EN: when defined, a held button repeats after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles; when undefined each
// press produces exactly one step (HELD state, no repeat counter).
module dot_btn_stepper
  import dot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       req_left,
  output logic       req_right,
  input  logic       step_ack,
  output logic [1:0] pressed,
  output logic [7:0] drop_cnt
);

  logic pl, pr;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_db_left (
    .clk    (clk),
    .rst    (rst),
    .btn_n  (btn_left),
    .pressed(pl)
  );

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_db_right (
    .clk    (clk),
    .rst    (rst),
    .btn_n  (btn_right),
    .pressed(pr)
  );

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  dir_e       fire_dir;
  logic       fire;
  logic       own, other;
  logic       req_left_q, req_left_d;
  logic       req_right_q, req_right_d;
  logic [7:0] drop_q, drop_d;
  logic       pending, retire;

`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rep_target;
  assign rep_target = (state_q == ST_DELAY) ? CNT_W'(REPEAT_DELAY - 1)
                                            : CNT_W'(REPEAT_PERIOD - 1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
`endif

  assign own   = (dir_q == DIR_LEFT) ? pl : pr;
  assign other = (dir_q == DIR_LEFT) ? pr : pl;

  // Next state and step events.  Release of the active side wins over a press
  // of the other side; both exits win over a repeat in the same cycle.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    fire     = 1'b0;
    fire_dir = dir_q;
`ifdef AUTO_REPEAT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pl && pr) begin
          state_d = ST_LOCK;
        end else if (pl || pr) begin
          fire     = 1'b1;
          fire_dir = pl ? DIR_LEFT : DIR_RIGHT;
          dir_d    = fire_dir;
`ifdef AUTO_REPEAT_EN
          cnt_d    = '0;
          state_d  = ST_DELAY;
`else
          state_d  = ST_HELD;
`endif
        end
      end
`ifdef AUTO_REPEAT_EN
      ST_DELAY, ST_REPEAT: begin
        if (!own) begin
          state_d = ST_IDLE;
        end else if (other) begin
          state_d = ST_LOCK;
        end else if (cnt_q == rep_target) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`else
      ST_HELD: begin
        if (!own) begin
          state_d = ST_IDLE;
        end else if (other) begin
          state_d = ST_LOCK;
        end
      end
`endif
      ST_LOCK: begin
        if (!pl && !pr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-entry handshake buffer: an ack in the same cycle as a new event frees
  // the slot so the new step loads instead of being dropped.
  assign pending = req_left_q | req_right_q;
  assign retire  = step_ack & pending;

  always_comb begin
    req_left_d  = req_left_q;
    req_right_d = req_right_q;
    drop_d      = drop_q;
    if (retire) begin
      req_left_d  = 1'b0;
      req_right_d = 1'b0;
    end
    if (fire) begin
      if (!pending || retire) begin
        req_left_d  = (fire_dir == DIR_LEFT);
        req_right_d = (fire_dir == DIR_RIGHT);
      end else if (drop_q != '1) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_LEFT;
      req_left_q  <= 1'b0;
      req_right_q <= 1'b0;
      drop_q      <= '0;
`ifdef AUTO_REPEAT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      req_left_q  <= req_left_d;
      req_right_q <= req_right_d;
      drop_q      <= drop_d;
`ifdef AUTO_REPEAT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_left  = req_left_q;
  assign req_right = req_right_q;
  assign pressed   = {pr, pl};
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_dot_btn_stepper.sv
// Self-checking bench for dot_btn_stepper with short timing
// (DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).  A behavioural model
// predicts outputs each cycle: debounce as "last DEBOUNCE_CYC synced samples
// all disagree", repeats as a schedule of ages since the first fire.
module tb_dot_btn_stepper;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_left = 1'b1;
  logic       btn_right = 1'b1;
  logic       step_ack = 1'b0;
  logic       req_left, req_right;
  logic [1:0] pressed;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  dot_btn_stepper #(
    .DEBOUNCE_CYC (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .CNT_W        (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .req_left (req_left),
    .req_right(req_right),
    .step_ack (step_ack),
    .pressed  (pressed),
    .drop_cnt (drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_ACTIVE, M_LOCK} mmode_e;

  logic [15:0] hist_l = '0, hist_r = '0;  // [0] = most recent raw sample (1 = pressed)
  bit          lvl_l = 0, lvl_r = 0;
  mmode_e      mode = M_IDLE;
  int          side = 0;
  int          age = 0;
  int          pend = -1;                 // -1 none, 0 left, 1 right
  int          drops = 0;
  int          ack_mode = 0;              // 0 never, 1 ack every pending step, 2 random

  task automatic model_reset();
    hist_l = '0; hist_r = '0;
    lvl_l = 0; lvl_r = 0;
    mode = M_IDLE; side = 0; age = 0;
    pend = -1; drops = 0;
  endtask

  function automatic bit flips(input logic [15:0] h, input bit level);
    logic [DB-1:0] w;
    w = h[DB:1];  // synced samples of the last DB cycles
    return level ? (w == '0) : (w == '1);
  endfunction

  task automatic model_edge();
    bit pl, pr, own, oth, fl, fr;
    int fire;
    if (rst) begin
      model_reset();
      return;
    end
    pl = lvl_l; pr = lvl_r; fire = -1;
    case (mode)
      M_IDLE: begin
        if (pl && pr) mode = M_LOCK;
        else if (pl || pr) begin
          fire = pl ? 0 : 1; side = fire; age = 0; mode = M_ACTIVE;
        end
      end
      M_ACTIVE: begin
        own = (side == 0) ? pl : pr;
        oth = (side == 0) ? pr : pl;
        if (!own) mode = M_IDLE;
        else if (oth) mode = M_LOCK;
        else begin
          age++;
          if (AUTO && age >= int'(RD) && ((age - int'(RD)) % int'(RP)) == 0) fire = side;
        end
      end
      default: if (!pl && !pr) mode = M_IDLE;
    endcase
    if (pend >= 0 && step_ack) pend = -1;
    if (fire >= 0) begin
      if (pend < 0) pend = fire;
      else if (drops < 255) drops++;
    end
    fl = flips(hist_l, lvl_l);
    fr = flips(hist_r, lvl_r);
    if (fl) lvl_l = ~lvl_l;
    if (fr) lvl_r = ~lvl_r;
    hist_l = {hist_l[14:0], ~btn_left};
    hist_r = {hist_r[14:0], ~btn_right};
  endtask

  // One clock: model and DUT advance on posedge, outputs compared on negedge,
  // then the ack input is chosen for the next edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("req_left",  32'(req_left),  32'(pend == 0));
    check("req_right", 32'(req_right), 32'(pend == 1));
    check("pressed",   32'(pressed),   32'({lvl_r, lvl_l}));
    check("drop_cnt",  32'(drop_cnt),  32'(drops));
    check("req_excl",  32'(req_left & req_right), 32'd0);
    case (ack_mode)
      1:       step_ack = (pend >= 0);
      2:       step_ack = 1'($urandom_range(0, 1));
      default: step_ack = 1'b0;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  int rises;
  logic prev_req;

  initial begin
    // reset
    run(3);
    check("rst_req", 32'({req_left, req_right}), 32'd0);
    check("rst_pressed", 32'(pressed), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    run(2);

    // 3-cycle glitch is rejected
    btn_left = 1'b0; run(3);
    btn_left = 1'b1; run(10);
    check("glitch_pressed", 32'(pressed), 32'd0);
    check("glitch_req", 32'(req_left), 32'd0);

    // press latency: pressed at +6, req at +7
    btn_left = 1'b0;
    run(5); check("lat_pressed5", 32'(pressed[0]), 32'd0);
    run(1); check("lat_pressed6", 32'(pressed[0]), 32'd1);
            check("lat_req6", 32'(req_left), 32'd0);
    run(1); check("lat_req7", 32'(req_left), 32'd1);

    // hold with acks: no drops
    ack_mode = 1;
    run(60);
    btn_left = 1'b1;
    run(15);
    check("hold_drop", 32'(drop_cnt), 32'd0);

    // steps per 100-cycle hold
    rises = 0; prev_req = req_left;
    btn_left = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (i == 100) btn_left = 1'b1;
      step();
      if (req_left && !prev_req) rises++;
      prev_req = req_left;
    end
    check("steps_per_hold", 32'(rises), AUTO ? 32'd11 : 32'd1);

    // both pressed -> lockout, then right press after release
    btn_left = 1'b0; btn_right = 1'b0; run(20);
    check("lock_req", 32'({req_left, req_right}), 32'd0);
    btn_left = 1'b1; btn_right = 1'b1; run(10);
    btn_right = 1'b0;
    run(6); check("unlock_req6", 32'(req_right), 32'd0);
    run(1); check("unlock_req7", 32'(req_right), 32'd1);

    // never ack: drops saturate
    ack_mode = 0;
    if (AUTO) run(2200);
    else begin
      for (int i = 0; i < 300; i++) begin
        btn_right = 1'b0; run(10);
        btn_right = 1'b1; run(10);
      end
    end
    btn_right = 1'b1; run(12);
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_req", 32'(req_right), 32'd1);
    ack_mode = 1; run(2);
    check("ack_clear", 32'(req_right), 32'd0);
    check("sat_drop_hold", 32'(drop_cnt), 32'd255);

    // rst mid-operation with button held
    ack_mode = 0;
    btn_left = 1'b0; run(30);
    rst = 1'b1; run(1);
    check("mid_rst_req", 32'({req_left, req_right}), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_pressed", 32'(pressed), 32'd0);
    rst = 1'b0;
    run(6); check("rst_redeb_req6", 32'(req_left), 32'd0);
    run(1); check("rst_redeb_req7", 32'(req_left), 32'd1);

    // randomized segments
    for (int seg = 0; seg < 200; seg++) begin
      ack_mode = int'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0, 1: repeat ($urandom_range(1, 12)) begin
          btn_left  = 1'($urandom_range(0, 1));
          btn_right = 1'($urandom_range(0, 1));
          run(1);
        end
        2, 3: begin btn_left = 1'b0; btn_right = 1'b1; run(int'($urandom_range(1, 60))); end
        4, 5: begin btn_left = 1'b1; btn_right = 1'b0; run(int'($urandom_range(1, 60))); end
        6:    begin btn_left = 1'b0; btn_right = 1'b0; run(int'($urandom_range(1, 30))); end
        7, 8: begin btn_left = 1'b1; btn_right = 1'b1; run(int'($urandom_range(1, 30))); end
        default: begin rst = 1'b1; run(1); rst = 1'b0; end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
